mult_result_buffer: RTL

- Credit-based result buffer that sits directly downstream of the mult unit.
- Captures every mult result (result, trans_id) into a small FIFO and presents it to the writeback port with a valid/ready handshake.
- Mult results carry no backpressure, so the block also gates issue into mult: an op may issue only when a buffer slot is guaranteed free.
- Flush discards all buffered and in-flight bookkeeping.

---
 rtl/mult_result_buffer_pkg.sv | 20 ++
 rtl/mult_result_fifo.sv | 74 +++++++
 rtl/mult_result_buffer.sv | 107 ++++++++++
 3 files changed

// File: rtl/mult_result_buffer_pkg.sv
// Purpose: shared widths and the buffered mult writeback entry type.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mult_result_buffer_pkg;

    localparam int unsigned XLEN_DEFAULT          = 64;
    localparam int unsigned TRANS_ID_BITS_DEFAULT = 3;
    localparam int unsigned DEPTH_DEFAULT         = 4;

    typedef struct packed {
        logic [TRANS_ID_BITS_DEFAULT-1:0] trans_id;
        logic [XLEN_DEFAULT-1:0]          result;
    } mult_wb_entry_t;

    // Counter width able to hold the value 'depth' itself without wrapping.
    function automatic int unsigned cnt_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/mult_result_fifo.sv
// Purpose: DEPTH-entry register FIFO holding mult results; head read straight from storage.
// Latency: an entry pushed in cycle N is at the head in cycle N+1 when previously empty.
// Backpressure: none on push; a push into a full FIFO without a same-cycle pop is dropped and flagged.
//
// Ports: clk_i/rst_i (async active-high), flush_i (clears pointers/count),
//        push_i/push_dat_i, pop_i, head_o, count_o, drop_o.
module mult_result_fifo
    import mult_result_buffer_pkg::*;
#(
    parameter int unsigned DEPTH   = DEPTH_DEFAULT,
    parameter type         entry_t = mult_wb_entry_t
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       flush_i,
    input  logic                       push_i,
    input  entry_t                     push_dat_i,
    input  logic                       pop_i,
    output entry_t                     head_o,
    output logic [cnt_width(DEPTH)-1:0] count_o,
    output logic                       drop_o
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = cnt_width(DEPTH);

    entry_t          storage [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [CW-1:0]   count;
    logic            full;
    logic            push_ok;
    logic            pop_ok;

    assign full    = (count == CW'(DEPTH));
    assign pop_ok  = pop_i && (count != '0) && !flush_i;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign push_ok = push_i && (!full || pop_ok) && !flush_i;
    assign drop_o  = push_i && full && !pop_ok && !flush_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                storage[i] <= '0;
            end
        end else if (push_ok) begin
            storage[wr_ptr] <= push_dat_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + PW'(1);
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    assign head_o  = storage[rd_ptr];
    assign count_o = count;

endmodule

// File: rtl/mult_result_buffer.sv
// Purpose: credit-gated result buffer behind the mult unit, presenting results to writeback.
// Latency: one cycle from mult_valid_i to wb_valid_o (no bypass).
// Backpressure: wb_ready_i low holds the head; issue_ready_o withholds issue once all credits are used.
//
// Ports: clk_i/rst_i, flush_i, issue_valid_i/issue_ready_o, mult_valid_i/mult_result_i/
//        mult_trans_id_i, wb_valid_o/wb_ready_i/wb_result_o/wb_trans_id_o, occupancy_o, err_o.
module mult_result_buffer
    import mult_result_buffer_pkg::*;
#(
    parameter int unsigned DEPTH         = DEPTH_DEFAULT,
    parameter int unsigned XLEN          = XLEN_DEFAULT,
    parameter int unsigned TRANS_ID_BITS = TRANS_ID_BITS_DEFAULT
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     flush_i,
    input  logic                     issue_valid_i,
    output logic                     issue_ready_o,
    input  logic                     mult_valid_i,
    input  logic [XLEN-1:0]          mult_result_i,
    input  logic [TRANS_ID_BITS-1:0] mult_trans_id_i,
    output logic                     wb_valid_o,
    input  logic                     wb_ready_i,
    output logic [XLEN-1:0]          wb_result_o,
    output logic [TRANS_ID_BITS-1:0] wb_trans_id_o,
    output logic [$clog2(DEPTH):0]   occupancy_o,
    output logic                     err_o
);

    localparam int unsigned CW = cnt_width(DEPTH);

    typedef struct packed {
        logic [TRANS_ID_BITS-1:0] trans_id;
        logic [XLEN-1:0]          result;
    } entry_t;

    entry_t          push_dat;
    entry_t          head;
    logic [CW-1:0]   count;
    logic [CW-1:0]   inflight;
    logic [CW:0]     credits_used;
    logic            issue_fire;
    logic            result_vld;
    logic            retire;
    logic            pop;
    logic            drop;
    logic            err_q;

    // Every issued op owns a slot until it has left the FIFO, so the
    // unbackpressurable mult result always finds space.
    assign credits_used  = {1'b0, count} + {1'b0, inflight};
    assign issue_ready_o = (credits_used < (CW+1)'(DEPTH));

    assign issue_fire = issue_valid_i && issue_ready_o && !flush_i;
    assign result_vld = mult_valid_i && !flush_i;
    // A stray result with nothing in flight must not underflow the counter.
    assign retire     = result_vld && (inflight != '0);
    assign pop        = wb_valid_o && wb_ready_i && !flush_i;

    assign push_dat.trans_id = mult_trans_id_i;
    assign push_dat.result   = mult_result_i;

    mult_result_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (entry_t)
    ) u_fifo (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .flush_i    (flush_i),
        .push_i     (result_vld),
        .push_dat_i (push_dat),
        .pop_i      (pop),
        .head_o     (head),
        .count_o    (count),
        .drop_o     (drop)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            inflight <= '0;
        end else if (flush_i) begin
            inflight <= '0;
        end else begin
            case ({issue_fire, retire})
                2'b10:   inflight <= inflight + CW'(1);
                2'b01:   inflight <= inflight - CW'(1);
                default: inflight <= inflight;
            endcase
        end
    end

    // Sticky until reset; flush deliberately leaves it set.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            err_q <= 1'b0;
        end else if (drop || (result_vld && (inflight == '0))) begin
            err_q <= 1'b1;
        end
    end

    assign err_o         = err_q;
    assign wb_valid_o    = (count != '0);
    assign wb_result_o   = head.result;
    assign wb_trans_id_o = head.trans_id;
    assign occupancy_o   = count;

endmodule
